// File: rtl/conv1_div_pkg.sv
// Shared types and defaults for the conv1 sequential unsigned divider.
package conv1_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIN0_W = 12;
  localparam int DIN1_W = 7;

  // Iteration counter width: must hold 0..w
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/conv1_udiv_step.sv
// One restoring-division iteration: shift in the dividend MSB, trial-subtract,
// keep the difference or restore.
module conv1_udiv_step #(
  parameter int din1_WIDTH = 7
) (
  input  logic [din1_WIDTH:0]   prem,
  input  logic [din1_WIDTH-1:0] dvs,
  input  logic                  msb,
  output logic [din1_WIDTH:0]   prem_nx,
  output logic                  qbit
);

  logic [din1_WIDTH:0]   shifted;
  logic [din1_WIDTH+1:0] diff;
  logic                  unused_top;

  // Top bit of the incoming remainder is shifted out by this step
  assign unused_top = prem[din1_WIDTH];
  assign shifted    = {prem[din1_WIDTH-1:0], msb};
  assign diff       = {1'b0, shifted} - {2'b00, dvs};
  assign qbit       = ~diff[din1_WIDTH+1];
  assign prem_nx    = qbit ? diff[din1_WIDTH:0] : shifted;

endmodule

// File: rtl/conv1_udiv_12ns_7ns_seq.sv
// Sequential unsigned restoring divider (row/col split of a flat index), one
// quotient bit per clock. Optional macro CONV1_UDIV_DIVZERO_CHK_EN: fast-path and flag zero divisors.
module conv1_udiv_12ns_7ns_seq
  import conv1_div_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [din0_WIDTH-1:0] dout_quo,
  output logic [din1_WIDTH-1:0] dout_rem,
  output logic                  dout_err
);

  localparam int CW = cnt_w(din0_WIDTH);

  state_t                state, state_nx;
  logic [din0_WIDTH-1:0] dvd;
  logic [din1_WIDTH-1:0] dvs;
  logic [din1_WIDTH:0]   prem, prem_nx;
  logic [CW-1:0]         cnt;
  logic [din0_WIDTH-1:0] quo_r;
  logic [din1_WIDTH-1:0] rem_r;
  logic                  qbit, accept, last, divz;
  logic                  unused_pmsb;

  assign unused_pmsb = prem_nx[din1_WIDTH];

`ifdef CONV1_UDIV_DIVZERO_CHK_EN
  logic err_r;
  assign divz     = (din1 == '0);
  assign dout_err = err_r;
`else
  assign divz     = 1'b0;
  assign dout_err = 1'b0;
`endif

  assign accept   = in_valid && in_ready;
  assign last     = (state == BUSY) && (cnt == CW'(din0_WIDTH - 1));
  assign dout_quo = quo_r;
  assign dout_rem = rem_r;

  conv1_udiv_step #(.din1_WIDTH(din1_WIDTH)) u_step (
    .prem    (prem),
    .dvs     (dvs),
    .msb     (dvd[din0_WIDTH-1]),
    .prem_nx (prem_nx),
    .qbit    (qbit)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Handshake outputs decode the state register only (plus reset hold-off)
  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE) && !ap_rst;
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = divz ? DONE : BUSY;
      BUSY:    if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dvd   <= '0;
      dvs   <= '0;
      prem  <= '0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
`ifdef CONV1_UDIV_DIVZERO_CHK_EN
      err_r <= 1'b0;
`endif
    end else if (accept) begin
      dvd  <= din0;
      dvs  <= din1;
      prem <= '0;
      cnt  <= '0;
`ifdef CONV1_UDIV_DIVZERO_CHK_EN
      err_r <= divz;
      if (divz) begin
        quo_r <= '1;
        rem_r <= din0[din1_WIDTH-1:0];
      end
`endif
    end else if (state == BUSY) begin
      // Dividend register doubles as the quotient shift register
      dvd  <= {dvd[din0_WIDTH-2:0], qbit};
      prem <= prem_nx;
      cnt  <= cnt + CW'(1);
      if (last) begin
        quo_r <= {dvd[din0_WIDTH-2:0], qbit};
        rem_r <= prem_nx[din1_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_conv1_udiv_12ns_7ns_seq.sv
// Directed-vector and random-stream bench for conv1_udiv_12ns_7ns_seq.
module tb_conv1_udiv_12ns_7ns_seq;

`ifdef CONV1_UDIV_DIVZERO_CHK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid, in_ready, out_valid, out_ready, dout_err;
  logic [11:0] din0, dout_quo;
  logic [6:0]  din1, dout_rem;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] a;
    logic [6:0]  b;
    logic [11:0] q;
    logic [6:0]  r;
  } vec_t;

  vec_t vt[9];
  logic [19:0] expq[$];

  conv1_udiv_12ns_7ns_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_quo  (dout_quo),
    .dout_rem  (dout_rem),
    .dout_err  (dout_err)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] model(input logic [11:0] a, input logic [6:0] b);
    if (b == 7'd0) return {DZ, 12'hFFF, a[6:0]};
    return {1'b0, 12'(a / b), 7'(a % b)};
  endfunction

  // Issue one pair, wait for the result, consume it with out_ready=1
  task automatic run_one(input logic [11:0] a, input logic [6:0] b,
                         output logic [11:0] q, output logic [6:0] r, output logic e,
                         output int lat, output logic rdy_busy);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge ap_clk); #1; n++; end
    in_valid = 1'b1; din0 = a; din1 = b;
    @(posedge ap_clk); #1;
    in_valid = 1'b0; din0 = 12'hA5A; din1 = 7'h55;
    lat = 0; rdy_busy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge ap_clk); #1;
      if (out_valid) begin lat = k; break; end
      rdy_busy |= in_ready;
    end
    q = dout_quo; r = dout_rem; e = dout_err;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [11:0] q, q0;
    logic [6:0]  r, r0;
    logic        e, rb;
    int          lat, bad, n, got, prod_to;

    vt[0] = '{12'd1000, 7'd27,  12'd37,   7'd1};
    vt[1] = '{12'd4095, 7'd1,   12'd4095, 7'd0};
    vt[2] = '{12'd5,    7'd100, 12'd0,    7'd5};
    vt[3] = '{12'd4095, 7'd127, 12'd32,   7'd31};
    vt[4] = '{12'd300,  7'd0,   12'd4095, 7'd44};
    vt[5] = '{12'd77,   7'd7,   12'd11,   7'd0};
    vt[6] = '{12'd0,    7'd5,   12'd0,    7'd0};
    vt[7] = '{12'd127,  7'd127, 12'd1,    7'd0};
    vt[8] = '{12'd2048, 7'd3,   12'd682,  7'd2};

    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din0 = '0; din1 = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_quo", dout_quo, 0);
    chk("rst_rem", dout_rem, 0);
    chk("rst_err", dout_err, 0);
    #20;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    foreach (vt[i]) begin
      run_one(vt[i].a, vt[i].b, q, r, e, lat, rb);
      chk($sformatf("v%0d_quo", i), q, vt[i].q);
      chk($sformatf("v%0d_rem", i), r, vt[i].r);
      chk($sformatf("v%0d_err", i), e, (DZ && vt[i].b == 0) ? 1 : 0);
      chk($sformatf("v%0d_lat", i), lat, (DZ && vt[i].b == 0) ? 1 : 12);
      chk($sformatf("v%0d_busy_rdy", i), rb, 0);
      chk($sformatf("v%0d_idle_rdy", i), in_ready, 1);
    end

    // Backpressure: result held for 20 cycles
    in_valid = 1'b1; din0 = 12'd2048; din1 = 7'd3;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge ap_clk); #1; n++; end
    q0 = dout_quo; r0 = dout_rem;
    chk("bp_valid", out_valid, 1);
    chk("bp_quo", q0, 682);
    chk("bp_rem", r0, 2);
    bad = 0;
    repeat (20) begin
      @(posedge ap_clk); #1;
      if (!out_valid || in_ready || dout_quo !== q0 || dout_rem !== r0) bad++;
    end
    chk("bp_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    chk("bp_consumed", out_valid, 0);
    chk("bp_idle", in_ready, 1);

    // Reset during iteration 5 of 1000/27
    in_valid = 1'b1; din0 = 12'd1000; din1 = 7'd27;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge ap_clk); #1; end
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_quo", dout_quo, 0);
    chk("mid_rst_rem", dout_rem, 0);
    chk("mid_rst_err", dout_err, 0);
    #12;
    ap_rst = 1'b0;
    bad = 0;
    repeat (15) begin @(posedge ap_clk); #1; if (out_valid) bad++; end
    chk("mid_rst_no_stale", bad, 0);
    run_one(12'd77, 7'd7, q, r, e, lat, rb);
    chk("after_rst_quo", q, 11);
    chk("after_rst_rem", r, 0);
    chk("after_rst_lat", lat, 12);

    // Random stream with gaps on both sides
    got = 0; prod_to = 0;
    fork
      begin
        logic [11:0] a;
        logic [6:0]  b;
        logic        rdy, acc;
        int          w;
        for (int i = 0; i < 200; i++) begin
          a = 12'($urandom);
          b = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
          repeat ($urandom_range(0, 3)) begin @(posedge ap_clk); #1; end
          in_valid = 1'b1; din0 = a; din1 = b;
          acc = 1'b0; w = 0;
          while (!acc && w < 200) begin
            rdy = in_ready;
            @(posedge ap_clk); #1;
            if (rdy) acc = 1'b1;
            w++;
          end
          in_valid = 1'b0;
          if (!acc) begin prod_to++; break; end
          expq.push_back(model(a, b));
        end
      end
      begin
        int c;
        c = 0;
        while (got < 200 && c < 20000) begin
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("stream_extra", 1, 0);
            else chk($sformatf("stream_%0d", got), {dout_err, dout_quo, dout_rem}, expq.pop_front());
            got++;
          end
          @(posedge ap_clk); #1;
          c++;
        end
        out_ready = 1'b0;
      end
    join
    chk("stream_count", got, 200);
    chk("stream_leftover", expq.size(), 0);
    chk("stream_prod_timeout", prod_to, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
